// File: rtl/cp0_regfile_p.sv
// Coprocessor-0 register file for the in-order MIPS32 pipeline (MEM/WB side):
// Count/Compare timer with prescaler, exception/ERET bookkeeping and interrupt request.
module cp0_regfile_p #(
  parameter int          INT_NUM      = 5,
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] STATUS_WMASK = 32'h1000_FF03,
  parameter logic [31:0] PRID_VAL     = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL   = 32'h0000_8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [4:0]         raddr_i,
  input  logic [31:0]        data_i,
  input  logic [INT_NUM-1:0] int_i,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic               eret_i,
  input  logic [31:0]        exc_pc_i,
  input  logic [31:0]        exc_badvaddr_i,
  input  logic               in_delayslot_i,
  output logic [31:0]        data_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        badvaddr_o,
  output logic               timer_int_o,
  output logic               int_req_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  REG_PRID     = 5'd15;
  localparam logic [4:0]  REG_CONFIG   = 5'd16;
  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
  // Only IV (23) and the software interrupt bits IP[9:8] are writable in Cause.
  localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
  localparam logic [8:0]  PRESC_MAX    = 9'(COUNT_DIV - 1);

  function automatic logic [31:0] merge_mask(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (new_val & mask) | (old_val & ~mask);
  endfunction

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] status_r;
  logic [31:0] cause_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [8:0]  presc_r;
  logic        timer_r;

  logic        mtc0_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic        wr_badvaddr_s;
  logic        presc_wrap_s;
  logic        timer_hit_s;
  logic        addr_exc_s;
  logic [4:0]  hw_ip_s;
  logic [31:0] status_next_s;
  logic [31:0] cause_next_s;
  logic [31:0] epc_next_s;
  logic [31:0] badvaddr_next_s;

  // MTC0 decode; a flushed instruction (exception or ERET this cycle) never writes.
  always_comb begin
    mtc0_s        = we_i & ~exc_valid_i & ~eret_i;
    wr_count_s    = mtc0_s & (waddr_i == REG_COUNT);
    wr_compare_s  = mtc0_s & (waddr_i == REG_COMPARE);
    wr_status_s   = mtc0_s & (waddr_i == REG_STATUS);
    wr_cause_s    = mtc0_s & (waddr_i == REG_CAUSE);
    wr_epc_s      = mtc0_s & (waddr_i == REG_EPC);
    wr_badvaddr_s = mtc0_s & (waddr_i == REG_BADVADDR);
    presc_wrap_s  = (presc_r == PRESC_MAX);
    timer_hit_s   = (compare_r != 32'd0) && (count_r == compare_r);
    addr_exc_s    = exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5));
  end

  // Hardware interrupt lines padded to the five IP[14:10] slots.
  always_comb begin
    hw_ip_s              = 5'd0;
    hw_ip_s[INT_NUM-1:0] = int_i;
  end

  // Next-state for Status, Cause, EPC and BadVAddr with exception > ERET > MTC0.
  always_comb begin
    status_next_s   = status_r;
    cause_next_s    = cause_r;
    epc_next_s      = epc_r;
    badvaddr_next_s = badvaddr_r;

    cause_next_s[15]    = timer_r;
    cause_next_s[14:10] = hw_ip_s;

    if (exc_valid_i) begin
      status_next_s[1]   = 1'b1;
      cause_next_s[6:2]  = exc_code_i;
      if (!status_r[1]) begin
        cause_next_s[31] = in_delayslot_i;
        epc_next_s       = in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end else begin
        cause_next_s[31] = cause_r[31];
        epc_next_s       = epc_r;
      end
    end else if (eret_i) begin
      status_next_s[1] = 1'b0;
    end else begin
      status_next_s = merge_mask(status_r, data_i, wr_status_s ? STATUS_WMASK : 32'h0000_0000);
      cause_next_s  = merge_mask(cause_next_s, data_i, wr_cause_s ? CAUSE_WMASK : 32'h0000_0000);
      epc_next_s    = wr_epc_s ? data_i : epc_r;
    end

    if (addr_exc_s) begin
      badvaddr_next_s = exc_badvaddr_i;
    end else if (wr_badvaddr_s) begin
      badvaddr_next_s = data_i;
    end else begin
      badvaddr_next_s = badvaddr_r;
    end
  end

  // Count and its prescaler; an MTC0 to Count restarts the prescale period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'd0;
      presc_r <= 9'd0;
    end else if (wr_count_s) begin
      count_r <= data_i;
      presc_r <= 9'd0;
    end else if (presc_wrap_s) begin
      count_r <= count_r + 32'd1;
      presc_r <= 9'd0;
    end else begin
      presc_r <= presc_r + 9'd1;
    end
  end

  // Compare register and sticky timer interrupt; writing Compare acknowledges it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_r <= 32'd0;
      timer_r   <= 1'b0;
    end else if (wr_compare_s) begin
      compare_r <= data_i;
      timer_r   <= 1'b0;
    end else if (timer_hit_s) begin
      timer_r   <= 1'b1;
    end
  end

  // Exception-related state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_r   <= STATUS_RST;
      cause_r    <= 32'd0;
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
    end else begin
      status_r   <= status_next_s;
      cause_r    <= cause_next_s;
      epc_r      <= epc_next_s;
      badvaddr_r <= badvaddr_next_s;
    end
  end

  // MFC0 read port: registered values only, no bypass of a same-cycle write.
  always_comb begin
    data_o = 32'd0;
    if (rst) begin
      data_o = 32'd0;
    end else begin
      case (raddr_i)
        REG_BADVADDR: data_o = badvaddr_r;
        REG_COUNT:    data_o = count_r;
        REG_COMPARE:  data_o = compare_r;
        REG_STATUS:   data_o = status_r;
        REG_CAUSE:    data_o = cause_r;
        REG_EPC:      data_o = epc_r;
        REG_PRID:     data_o = PRID_VAL;
        REG_CONFIG:   data_o = CONFIG_VAL;
        default:      data_o = 32'd0;
      endcase
    end
  end

  assign count_o     = count_r;
  assign compare_o   = compare_r;
  assign status_o    = status_r;
  assign cause_o     = cause_r;
  assign epc_o       = epc_r;
  assign badvaddr_o  = badvaddr_r;
  assign timer_int_o = timer_r;
  assign int_req_o   = status_r[0] & ~status_r[1] & (|(cause_r[15:8] & status_r[15:8]));

endmodule
